// File: rtl/product_packer_27_pkg.sv
// Shared definitions for the product packer and the 27-input adder tree.
// Both sides use slot_lsb() so they agree on where each element sits in the packed bus.
package product_packer_27_pkg;

    localparam int NUM_INPUTS = 27;
    localparam int BITSIZE    = 14;
    localparam int CNT_W      = 5;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int slot_lsb(input int i, input int width = BITSIZE);
        return i * width;
    endfunction

endpackage

// File: rtl/product_packer_27_vec_hold_reg.sv
// Output register O: holds one packed vector plus its element count behind a valid/ready handshake.
// Loading always wins; a transfer without a load empties the register.
module vec_hold_reg #(
    parameter int VEC_W = 378,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [VEC_W-1:0] vec_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             out_ready_i,
    output logic [VEC_W-1:0] out_numbers_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_valid_o
);

    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    always_comb begin
        vec_d   = vec_q;
        count_d = count_q;
        valid_d = valid_q;
        if (load_i) begin
            vec_d   = vec_i;
            count_d = count_i;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            vec_q   <= vec_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign out_numbers_o = vec_q;
    assign out_count_o   = count_q;
    assign out_valid_o   = valid_q;

endmodule

// File: rtl/product_packer_27.sv
// Serial-to-parallel packer: collects up to NUM_INPUTS signed products into one packed vector
// for the adder tree; short windows end on in_last and are zero-padded.
module product_packer_27 #(
    parameter int bitsize    = product_packer_27_pkg::BITSIZE,
    parameter int NUM_INPUTS = product_packer_27_pkg::NUM_INPUTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [bitsize-1:0]            in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [NUM_INPUTS*bitsize-1:0] out_numbers,
    output logic [4:0]                    out_count,
    output logic                          out_valid,
    input  logic                          out_ready
);
    import product_packer_27_pkg::*;

    localparam int VEC_W = NUM_INPUTS * bitsize;

    logic [bitsize-1:0] fill_q [NUM_INPUTS];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_e             state_q, state_d;

    logic             accept, complete, o_free, load_o;
    logic [VEC_W-1:0] load_vec;
    logic [CNT_W-1:0] load_count;

    // Ready is forced low combinationally so nothing is accepted while reset is held.
    assign in_ready = (state_q == ST_FILL) && !rst;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt_q == CNT_W'(NUM_INPUTS - 1)));
    assign o_free   = !out_valid || out_ready;

    // The completing element bypasses F so it lands in O on the same edge it is accepted.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slot
        assign load_vec[slot_lsb(gi, bitsize) +: bitsize] =
            (accept && (cnt_q == CNT_W'(gi))) ? in_data : fill_q[gi];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_o     = 1'b0;
        load_count = cnt_q + CNT_W'(1);
        case (state_q)
            ST_FILL: begin
                if (complete && o_free) begin
                    load_o = 1'b1;
                    cnt_d  = '0;
                end else if (complete) begin
                    // cnt_q now records the pending element count rather than the next slot.
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_HOLD;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                load_count = cnt_q;
                if (out_valid && out_ready) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) fill_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (load_o)
                    fill_q[i] <= '0;
                else if (accept && (cnt_q == CNT_W'(i)))
                    fill_q[i] <= in_data;
            end
        end
    end

    vec_hold_reg #(
        .VEC_W(VEC_W),
        .CNT_W(CNT_W)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_o),
        .vec_i        (load_vec),
        .count_i      (load_count),
        .out_ready_i  (out_ready),
        .out_numbers_o(out_numbers),
        .out_count_o  (out_count),
        .out_valid_o  (out_valid)
    );

endmodule

// File: tb/tb_product_packer_27.sv
// Bench for product_packer_27: table of windows streamed through a queue scoreboard,
// plus hand sequences for backpressure and mid-window reset.
module tb_product_packer_27;

    localparam int B  = 14;
    localparam int N  = 27;
    localparam int VW = N * B;

    logic          clk = 1'b0;
    logic          rst;
    logic [B-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [VW-1:0] out_numbers;
    logic [4:0]    out_count;
    logic          out_valid;
    logic          out_ready;

    product_packer_27 dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_numbers(out_numbers),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [VW-1:0] vec;
        logic [4:0]    cnt;
    } exp_t;

    exp_t         sb_q [$];
    logic [B-1:0] win  [$];
    exp_t         e_m;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] build_vec(input int start, input int step, input int len);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[i*B +: B] = B'(start + i * step);
        return v;
    endfunction

    // Scoreboard: model windows from accepted elements, compare on every transfer.
    always @(negedge clk) begin
        if (rst) begin
            win.delete();
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                win.push_back(in_data);
                if (in_last || win.size() == N) begin
                    e_m.vec = '0;
                    foreach (win[k]) e_m.vec[k*B +: B] = win[k];
                    e_m.cnt = 5'(win.size());
                    sb_q.push_back(e_m);
                    win.delete();
                end
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got vector count=%0d want no output", out_count);
                end else begin
                    e_m = sb_q.pop_front();
                    chk("sb_vec", 512'(out_numbers), 512'(e_m.vec));
                    chk("sb_count", 512'(out_count), 512'(e_m.cnt));
                    $display("xfer count=%0d slot0=%0h", out_count, out_numbers[B-1:0]);
                end
            end
        end
    end

    task automatic send(input logic [B-1:0] d, input bit last, output int stalls);
        bit ok;
        ok       = 1'b0;
        stalls   = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!ok && stalls < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 512'(ok), 512'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct {
        int len;
        int start;
        int step;
        bit last;
        int exp_count;
    } vec_t;

    vec_t tab [6];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, stall_sum, w;

        tab[0] = '{len: 27, start: 1,     step: 1,    last: 1'b0, exp_count: 27};
        tab[1] = '{len: 9,  start: 1,     step: 1,    last: 1'b1, exp_count: 9};
        tab[2] = '{len: 27, start: -1,    step: 0,    last: 1'b0, exp_count: 27};
        tab[3] = '{len: 1,  start: 1234,  step: 0,    last: 1'b1, exp_count: 1};
        tab[4] = '{len: 5,  start: -8000, step: 3000, last: 1'b1, exp_count: 5};
        tab[5] = '{len: 27, start: 5000,  step: -371, last: 1'b1, exp_count: 27};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_count", 512'(out_count), 512'(0));
        chk("rst_out_numbers", 512'(out_numbers), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            stall_sum = 0;
            for (int k = 0; k < tab[t].len; k++) begin
                send(B'(tab[t].start + k * tab[t].step), tab[t].last && (k == tab[t].len - 1), st);
                stall_sum += st;
            end
            chk("latency_valid", 512'(out_valid), 512'(1));
            chk("tab_count", 512'(out_count), 512'(tab[t].exp_count));
            chk("no_stall", 512'(stall_sum), 512'(0));
        end
        chk("neg_all_3fff", 512'(build_vec(-1, 0, 27)), 512'({27{14'h3FFF}}));
        idle();
        @(posedge clk);
        #1;

        // Backpressure: two full windows with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 27; k++) send(B'(1 + k), 1'b0, st);
        for (int k = 0; k < 27; k++) send(B'(101 + k), 1'b0, st);
        idle();
        chk("bp_in_ready_low", 512'(in_ready), 512'(0));
        chk("bp_valid", 512'(out_valid), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stable_vec", 512'(out_numbers), 512'(build_vec(1, 1, 27)));
        chk("bp_still_held", 512'(in_ready), 512'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_reload_valid", 512'(out_valid), 512'(1));
        chk("bp_reload_vec", 512'(out_numbers), 512'(build_vec(101, 1, 27)));
        chk("bp_in_ready_back", 512'(in_ready), 512'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drained", 512'(out_valid), 512'(0));

        // Reset in the middle of a window.
        for (int k = 0; k < 13; k++) send(B'(900 + k), 1'b0, st);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_in_ready", 512'(in_ready), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 27; k++) send(B'(500 + 7 * k), 1'b0, st);
        idle();
        chk("rst_new_vec", 512'(out_numbers), 512'(build_vec(500, 7, 27)));
        chk("rst_new_count", 512'(out_count), 512'(27));

        w = 0;
        while (sb_q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("sb_drain", 512'(sb_q.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
